// File: rtl/serial_magnitude_comparator_pkg.sv
// serial_magnitude_comparator_pkg: FSM state and decision encodings shared by the comparator files.
package serial_magnitude_comparator_pkg;
    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
    typedef enum logic [1:0] {UNDECIDED, GT, LT} dec_t;
endpackage

// File: rtl/serial_magnitude_comparator_cmp_bit_cell.sv
// cmp_bit_cell: folds one MSB-first bit pair into the running decision; the first differing pair wins.
module cmp_bit_cell
    import serial_magnitude_comparator_pkg::*;
(
    input  logic [1:0] dec_in,
    input  logic       a_bit,
    input  logic       b_bit,
    output logic [1:0] dec_out
);
    always_comb begin
        dec_out = (dec_in != UNDECIDED || a_bit == b_bit) ? dec_in : (a_bit ? GT : LT);
    end
endmodule

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: MSB-first bit-serial compare of A and B with a one-cycle result pulse.
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int MAX_BITS = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             a_bit,
    input  logic             b_bit,
    input  logic             bit_last,
    output logic             res_valid,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             overflow,
    output logic [CNT_W-1:0] bit_count
);
    state_t           state, state_nxt;
    logic [1:0]       dec, dec_prev, dec_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             xfer, finish;

    cmp_bit_cell u_cell (
        .dec_in (dec_prev),
        .a_bit  (a_bit),
        .b_bit  (b_bit),
        .dec_out(dec_nxt)
    );

    // The first pair of a comparison always starts from UNDECIDED, whatever dec still holds.
    always_comb begin
        bit_ready = state != DONE;
        res_valid = state == DONE;
        xfer      = bit_valid && bit_ready;
        dec_prev  = state == IDLE ? UNDECIDED : dec;
        cnt_nxt   = state == IDLE ? CNT_W'(1) : bit_count + 1'b1;
        finish    = xfer && (bit_last || cnt_nxt == CNT_W'(MAX_BITS));
        state_nxt = state == DONE ? IDLE : finish ? DONE : xfer ? COMPARE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dec       <= UNDECIDED;
            bit_count <= '0;
            a_gt_b    <= 1'b0;
            a_eq_b    <= 1'b1;
            a_lt_b    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                dec       <= dec_nxt;
                bit_count <= cnt_nxt;
            end
            if (finish) begin
                a_gt_b   <= dec_nxt == GT;
                a_eq_b   <= dec_nxt == UNDECIDED;
                a_lt_b   <= dec_nxt == LT;
                overflow <= !bit_last;
            end
        end
    end
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator: table-driven vectors plus hand sequences for gaps, held valid and mid-run reset.
module tb_serial_magnitude_comparator;
    logic       clk = 1'b0;
    logic       rst;
    logic       bit_valid, bit_ready, a_bit, b_bit, bit_last;
    logic       res_valid, a_gt_b, a_eq_b, a_lt_b, overflow;
    logic [4:0] bit_count;
    int         compared = 0;
    int         mismatched = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          n;
        logic        last;
        logic [2:0]  gle;
        logic        ovf;
        int          cnt;
    } vec_t;
    vec_t vecs[10];

    serial_magnitude_comparator #(.MAX_BITS(16), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .a_bit    (a_bit),
        .b_bit    (b_bit),
        .bit_last (bit_last),
        .res_valid(res_valid),
        .a_gt_b   (a_gt_b),
        .a_eq_b   (a_eq_b),
        .a_lt_b   (a_lt_b),
        .overflow (overflow),
        .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents a pair at a negedge and returns at the negedge after it was accepted; bit_valid stays high.
    task automatic send_pair(input logic a, input logic b, input logic last);
        int w = 0;
        bit_valid = 1'b1;
        a_bit     = a;
        b_bit     = b;
        bit_last  = last;
        while (!bit_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (!bit_ready) chk("ready_timeout", 32'(bit_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int n, input logic last);
        for (int i = n - 1; i >= 0; i--) send_pair(a[i], b[i], last && i == 0);
        bit_valid = 1'b0;
    endtask

    // Called in the DONE cycle; also checks the pulse drops and the result holds one cycle later.
    task automatic check_result(input string name, input logic [2:0] gle, input logic ovf, input int cnt);
        chk({name, "_res_valid"}, 32'(res_valid), 32'd1);
        chk({name, "_ready_done"}, 32'(bit_ready), 32'd0);
        chk({name, "_flags"}, 32'({a_gt_b, a_eq_b, a_lt_b}), 32'(gle));
        chk({name, "_onehot"}, 32'($countones({a_gt_b, a_eq_b, a_lt_b})), 32'd1);
        chk({name, "_overflow"}, 32'(overflow), 32'(ovf));
        chk({name, "_count"}, 32'(bit_count), 32'(cnt));
        @(negedge clk);
        chk({name, "_pulse_end"}, 32'(res_valid), 32'd0);
        chk({name, "_held"}, 32'({a_gt_b, a_eq_b, a_lt_b, overflow}), 32'({gle, ovf}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h000B, 16'h0009, 4,  1'b1, 3'b100, 1'b0, 4};
        vecs[1] = '{16'h5A5A, 16'h5A5A, 16, 1'b1, 3'b010, 1'b0, 16};
        vecs[2] = '{16'h5A5A, 16'h5A5A, 16, 1'b0, 3'b010, 1'b1, 16};
        vecs[3] = '{16'h0000, 16'h0000, 1,  1'b1, 3'b010, 1'b0, 1};
        vecs[4] = '{16'h0000, 16'h0001, 1,  1'b1, 3'b001, 1'b0, 1};
        vecs[5] = '{16'h0001, 16'h0000, 1,  1'b1, 3'b100, 1'b0, 1};
        vecs[6] = '{16'h0001, 16'h0001, 1,  1'b1, 3'b010, 1'b0, 1};
        vecs[7] = '{16'h0001, 16'h0000, 16, 1'b1, 3'b100, 1'b0, 16};
        vecs[8] = '{16'h8000, 16'h7FFF, 16, 1'b0, 3'b100, 1'b1, 16};
        vecs[9] = '{16'h0002, 16'h0003, 3,  1'b1, 3'b001, 1'b0, 3};
        rst       = 1'b1;
        bit_valid = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        bit_last  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(bit_ready), 32'd1);
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_flags", 32'({a_gt_b, a_eq_b, a_lt_b, overflow}), 32'b0100);
        chk("reset_count", 32'(bit_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 10; k++) begin
            run_op(vecs[k].a, vecs[k].b, vecs[k].n, vecs[k].last);
            check_result($sformatf("vec%0d", k), vecs[k].gle, vecs[k].ovf, vecs[k].cnt);
        end

        // Pair held valid through DONE is taken only in the following IDLE cycle.
        bit_valid = 1'b1; a_bit = 1'b0; b_bit = 1'b1; bit_last = 1'b1;
        @(negedge clk);
        chk("hold_first_lt", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'b001);
        chk("hold_first_count", 32'(bit_count), 32'd1);
        chk("hold_ready_done", 32'(bit_ready), 32'd0);
        chk("hold_res_valid", 32'(res_valid), 32'd1);
        a_bit = 1'b1; b_bit = 1'b0;
        @(negedge clk);
        chk("hold_idle_ready", 32'(bit_ready), 32'd1);
        chk("hold_idle_no_pulse", 32'(res_valid), 32'd0);
        chk("hold_idle_count", 32'(bit_count), 32'd1);
        @(negedge clk);
        bit_valid = 1'b0;
        check_result("hold_second", 3'b100, 1'b0, 1);

        // A=0110, B=1000 with a three-cycle gap between pairs 2 and 3.
        send_pair(1'b0, 1'b1, 1'b0);
        send_pair(1'b1, 1'b0, 1'b0);
        bit_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("gap_no_pulse", 32'(res_valid), 32'd0);
            chk("gap_prev_held", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'b100);
        end
        chk("gap_count", 32'(bit_count), 32'd2);
        send_pair(1'b1, 1'b0, 1'b0);
        send_pair(1'b0, 1'b0, 1'b1);
        bit_valid = 1'b0;
        check_result("gap", 3'b001, 1'b0, 4);

        // Reset in the middle of a comparison that was heading for GT.
        send_pair(1'b1, 1'b0, 1'b0);
        send_pair(1'b1, 1'b1, 1'b0);
        bit_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_ready", 32'(bit_ready), 32'd1);
        chk("midrst_flags", 32'({a_gt_b, a_eq_b, a_lt_b, overflow}), 32'b0100);
        chk("midrst_count", 32'(bit_count), 32'd0);
        @(negedge clk);
        chk("midrst_no_pulse", 32'(res_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op(16'h0003, 16'h0003, 4, 1'b1);
        check_result("after_rst", 3'b010, 1'b0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/serial_magnitude_comparator.md
SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 Parameter MAX_BITS, default 16, maximum operand length in bits accepted per comparison.
REQ-002 Parameter CNT_W, default 5, bit-counter width; SHALL satisfy 2**CNT_W > MAX_BITS.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 bit_valid  input  1  a_bit/b_bit/bit_last valid this cycle.
REQ-006 bit_ready  output  1  block accepts a bit pair this cycle.
REQ-007 a_bit  input  1  current bit of operand A, MSB first.
REQ-008 b_bit  input  1  current bit of operand B, MSB first.
REQ-009 bit_last  input  1  current pair is the LSB (final pair) of the operands.
REQ-010 res_valid  output  1  one-cycle pulse, result outputs valid.
REQ-011 a_gt_b  output  1  A > B, held from res_valid until next result.
REQ-012 a_eq_b  output  1  A == B, held likewise.
REQ-013 a_lt_b  output  1  A < B, held likewise.
REQ-014 overflow  output  1  comparison terminated at MAX_BITS without bit_last, held with result.
REQ-015 bit_count  output  CNT_W  number of pairs accepted in the current/last comparison.

Function
REQ-016 Transfer occurs when bit_valid && bit_ready on a rising clk edge; no other cycle changes decision state.
REQ-017 FSM states: IDLE, COMPARE, DONE.
REQ-018 IDLE: bit_ready=1; first transfer clears bit_count to 1, loads decision from the pair, goes to COMPARE (or DONE if bit_last).
REQ-019 COMPARE: bit_ready=1; each transfer increments bit_count; goes to DONE on bit_last, or on the transfer making bit_count == MAX_BITS.
REQ-020 DONE: bit_ready=0, res_valid=1 for exactly this one cycle, result outputs updated, unconditional return to IDLE next cycle.
REQ-021 Latency: res_valid asserts the cycle after the transfer carrying bit_last.
REQ-022 Decision rule: internal state UNDECIDED/GT/LT; while UNDECIDED, a=1,b=0 -> GT; a=0,b=1 -> LT; equal -> UNDECIDED; once GT or LT, later bits are consumed but ignored.
REQ-023 Result mapping: GT -> a_gt_b; LT -> a_lt_b; UNDECIDED -> a_eq_b; exactly one of the three SHALL be 1 after the first result.
REQ-024 overflow SHALL be 1 only when DONE was entered via MAX_BITS count without bit_last on that transfer; bit_last on the MAX_BITS-th transfer gives overflow=0.
REQ-025 bit_valid low in COMPARE: state held indefinitely, no timeout.
REQ-026 bit_valid during DONE: not accepted (bit_ready=0); source SHALL hold it, pair is taken in the following IDLE cycle.
REQ-027 Result outputs and overflow SHALL hold their values outside DONE, unchanged while a new comparison is in progress.
REQ-028 bit_count SHALL not wrap; saturates at MAX_BITS by construction of REQ-019.

Reset
REQ-029 rst asserted at any time, including mid-comparison, SHALL immediately force IDLE, discard partial decision, no res_valid pulse.
REQ-030 Reset values: bit_ready=1 (after state=IDLE), res_valid=0, a_gt_b=0, a_eq_b=1, a_lt_b=0, overflow=0, bit_count=0.
REQ-031 First transfer after rst deassertion SHALL start a new comparison normally.

Structure
REQ-032 Shared package/header SHALL hold FSM state encodings (IDLE, COMPARE, DONE) and decision encodings (UNDECIDED, GT, LT).
REQ-033 One sub-module, cmp_bit_cell: combinational, inputs prior decision + a_bit + b_bit, outputs next decision per REQ-022.
REQ-034 All registers in the top level; no latches, no gated clocks.

Verification
REQ-035 A=1011, B=1001 (4 bits, bit_last on 4th) -> res_valid one cycle after 4th transfer, a_gt_b=1, a_eq_b=0, a_lt_b=0, overflow=0, bit_count=4.
REQ-036 A=0110, B=1000 with bit_valid low 3 cycles between pairs 2 and 3 -> a_lt_b=1, decision from MSB unaffected by later bits and gaps.
REQ-037 A=B=0x5A5A, 16 bits, bit_last on 16th -> a_eq_b=1, overflow=0; repeat with no bit_last -> DONE after 16th, a_eq_b=1, overflow=1.
REQ-038 Single pair a=0,b=1 with bit_last -> a_lt_b=1, bit_count=1; bit_valid held high through DONE -> bit_ready=0 in DONE, next pair accepted in IDLE.
REQ-039 rst pulsed after 2 of 4 pairs -> no res_valid, outputs at reset values, fresh 4-bit comparison A=0011,B=0011 -> a_eq_b=1.
REQ-040 All exhaustive 1-bit pairs (00,01,10,11) with bit_last -> eq, lt, gt, eq respectively, exactly one result flag high each time.
